// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory access arbiter: FSM states, access owner
// and the word-alignment mask.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_t;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a debug
// port, sequencing one word access at a time against a fixed-latency memory.
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              dbg_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       stall_cnt_o
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    state_t            r_state, w_state;
    owner_t            r_owner, w_owner;
    owner_t            r_last_grant, w_last_grant;
    logic              r_we, w_we;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic              r_cpu_ack, w_cpu_ack;
    logic              r_cpu_err, w_cpu_err;
    logic              r_dbg_ack, w_dbg_ack;
    logic              r_dbg_err, w_dbg_err;
    logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata, w_dbg_rdata;
    logic [31:0]       r_stall_cnt;
    logic              w_misalign;
    logic              w_cpu_stall;

    // Gated by reset so every output reads 0 while the block is held in reset.
    assign w_cpu_stall = cpu_req_i & ~r_cpu_ack & ~rst_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_grant = r_last_grant;
        w_we         = r_we;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_cnt        = r_cnt;
        w_misalign   = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_cpu_ack    = 1'b0;
        w_cpu_err    = 1'b0;
        w_dbg_ack    = 1'b0;
        w_dbg_err    = 1'b0;
        w_cpu_rdata  = r_cpu_rdata;
        w_dbg_rdata  = r_dbg_rdata;

        case (r_state)
            IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    // A lone requester wins; on a tie the port not granted last time wins.
                    w_owner = (cpu_req_i && (!dbg_req_i || r_last_grant == OWN_DBG))
                              ? OWN_CPU : OWN_DBG;
                    w_last_grant = w_owner;
                    if (w_owner == OWN_CPU) begin
                        w_we    = cpu_we_i;
                        w_addr  = cpu_addr_i;
                        w_wdata = cpu_wdata_i;
                    end else begin
                        w_we    = dbg_we_i;
                        w_addr  = dbg_addr_i;
                        w_wdata = dbg_wdata_i;
                    end
                    w_misalign = (w_addr[1:0] & MISALIGN_MASK) != 2'b00;
                    if (w_misalign) begin
                        w_state = RESP;
                        if (w_owner == OWN_CPU) begin
                            w_cpu_ack   = 1'b1;
                            w_cpu_err   = 1'b1;
                            w_cpu_rdata = '0;
                        end else begin
                            w_dbg_ack   = 1'b1;
                            w_dbg_err   = 1'b1;
                            w_dbg_rdata = '0;
                        end
                    end else begin
                        w_state  = ISSUE;
                        w_mem_en = 1'b1;
                        w_mem_we = w_we;
                    end
                end
            end
            ISSUE: begin
                w_state = WAIT;
                w_cnt   = CNT_W'(MEM_LAT);
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state = RESP;
                    if (r_owner == OWN_CPU) begin
                        w_cpu_ack = 1'b1;
                        if (!r_we) w_cpu_rdata = mem_rdata_i;
                    end else begin
                        w_dbg_ack = 1'b1;
                        if (!r_we) w_dbg_rdata = mem_rdata_i;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DBG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_dbg_err    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_grant <= w_last_grant;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_cnt        <= w_cnt;
            r_mem_en     <= w_mem_en;
            r_mem_we     <= w_mem_we;
            r_cpu_ack    <= w_cpu_ack;
            r_cpu_err    <= w_cpu_err;
            r_dbg_ack    <= w_dbg_ack;
            r_dbg_err    <= w_dbg_err;
            r_cpu_rdata  <= w_cpu_rdata;
            r_dbg_rdata  <= w_dbg_rdata;
            if (w_cpu_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cpu_rdata_o = r_cpu_rdata;
    assign cpu_ack_o   = r_cpu_ack;
    assign cpu_err_o   = r_cpu_err;
    assign cpu_stall_o = w_cpu_stall;
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_ack_o   = r_dbg_ack;
    assign dbg_err_o   = r_dbg_err;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Arbitrates the single-port data memory of the pipelined CPU between two requesters: the CPU MEM stage and a debug/loader port used by benches to preload and dump memory. Sequences each word access against a fixed-latency memory. Freezes the pipeline through a stall output until the CPU access completes. Keeps a saturating count of CPU stall cycles for performance checks.

Parameters:
ADDR_W, 7, byte-address width (128-byte data memory)
DATA_W, 32, word width
MEM_LAT, 2, cycles from the mem_en_o cycle to valid mem_rdata_i (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
cpu_req_i  in  1  CPU access request, held until ack
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  ADDR_W  byte address
cpu_wdata_i  in  DATA_W  write data
cpu_rdata_o  out  DATA_W  read data, valid with ack, held until next ack
cpu_ack_o  out  1  one-cycle completion pulse
cpu_err_o  out  1  misaligned-access pulse, coincident with ack
cpu_stall_o  out  1  pipeline freeze
dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i  in  1/1/ADDR_W/DATA_W  debug request, same rules as CPU
dbg_rdata_o / dbg_ack_o / dbg_err_o  out  DATA_W/1/1  debug response, same rules as CPU
mem_en_o  out  1  memory access strobe, one cycle
mem_we_o  out  1  memory write enable, only with mem_en_o
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched write data
mem_rdata_i  in  DATA_W  memory read data
stall_cnt_o  out  32  saturating count of cycles with cpu_stall_o=1

Behaviour:
- Reset (async, immediate): state IDLE; last_grant=DBG; all outputs 0, including rdata and stall_cnt_o. An in-flight access is aborted with no ack.
- FSM: IDLE, ISSUE, WAIT, RESP. All outputs are registered except cpu_stall_o.
- IDLE: if any req is high, pick a winner and latch owner/we/addr/wdata.
  - Aligned address (addr[1:0]==0): go to ISSUE.
  - Misaligned: go straight to RESP with err; no memory access; rdata=0.
- Arbitration: a single requester always wins. On a tie, the requester not named in last_grant wins. last_grant updates at every grant, so the CPU wins the first tie after reset.
- ISSUE, one cycle: mem_en_o=1; mem_we_o=latched we; mem_addr_o/mem_wdata_o=latched values. Next state is WAIT with counter = MEM_LAT.
- WAIT, MEM_LAT cycles: mem_en_o=0. On the last WAIT cycle, capture mem_rdata_i into the owner's rdata register (reads only) and go to RESP.
- RESP, one cycle: owner's ack=1; err=1 if misaligned. Next state is IDLE.
- Aligned access timeline, request first seen in IDLE at cycle 0: ISSUE at cycle 1, ack at cycle MEM_LAT+2. Misaligned: ack at cycle 1.
- Requester protocol: req and payload stay stable until ack. In the cycle after ack, req must be low or carry a new request. A high req in IDLE is always a new access.
- The non-owner's rdata is unchanged. A write access leaves rdata unchanged.
- cpu_stall_o = cpu_req_i & ~cpu_ack_o (combinational), so the pipeline also freezes while the debug port owns memory.
- stall_cnt_o increments on each clock with cpu_stall_o=1 and saturates at 32'hFFFF_FFFF.
- No back-to-back issue: at least one IDLE cycle between accesses.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_CPU, OWN_DBG}
  - MISALIGN_MASK=2'b11 constant
- No sub-module required. Round-robin pick and wait counter stay inline.

Test Plan:
1. Hold rst_i=1 with random requests -> all outputs 0, no mem_en_o. Assert rst_i asynchronously mid-cycle -> outputs clear before the next edge.
2. CPU read, addr 7'h08; memory returns 32'h0000_00AB in cycle 3 -> mem_en_o=1, mem_we_o=0 in cycle 1 only; cpu_ack_o in cycle 4 with cpu_rdata_o=32'h0000_00AB; cpu_stall_o high in cycles 0-3; stall_cnt_o=4 afterwards.
3. CPU write, addr 7'h10, data 32'hDEAD_BEEF -> cycle 1 shows mem_we_o=1, mem_addr_o=7'h10, mem_wdata_o=32'hDEAD_BEEF; ack in cycle 4; cpu_rdata_o unchanged.
4. Both ports request continuously from cycle 0 after reset, each reissuing a new request after its ack -> grant order CPU (ack cycle 4), DBG (ack cycle 9), CPU (ack cycle 14). cpu_stall_o stays high during the DBG access.
5. CPU read, addr 7'h05 -> no mem_en_o; cpu_ack_o=1 and cpu_err_o=1 in cycle 1; cpu_rdata_o=0.
6. rst_i pulsed during WAIT of a DBG read -> no dbg_ack_o. After release with dbg_req_i still high -> fresh arbitration and ISSUE; ack at MEM_LAT+2 cycles after the IDLE cycle.
